pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Hazard interlock and stall sequencer for the 5-stage MIPS pipeline; sits beside the decode stage.
- Keeps its own shadow scoreboard of destination registers in EX and MEM.
- Decides each cycle whether the ID instruction advances, is held with a bubble injected into EX, or the whole pipe freezes for memory wait.
- Gates the decode jump/branch redirect so it only fires on a cycle where ID operands are valid.

Parameters:
- MAX_STALL, 4, consecutive interlock cycles tolerated before the deadlock flag sets.
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ext_stall  in  1  memory not ready; freeze entire pipe
- valid_id  in  1  ID holds a real instruction
- reg_s_addr  in  5  rs of ID instruction
- reg_t_addr  in  5  rt of ID instruction
- use_s  in  1  ID reads rs
- use_t  in  1  ID reads rt
- cmp_id  in  1  ID consumes operands in ID (branch compare, jr)
- jump  in  1  redirect request from decode
- dst_we_id  in  1  ID instruction writes a register
- dst_addr_id  in  5  ID destination
- load_id  in  1  ID instruction is a load
- stall  out  1  hold PC and IF/ID register
- bubble_ex  out  1  zero EX control (reg/mem write enables) on next edge
- redirect  out  1  jump AND NOT stall
- deadlock  out  1  sticky watchdog flag
- stall_cnt  out  CNT_W  interlock cycles (optional feature)
- hold_cnt  out  CNT_W  ext_stall cycles (optional feature)

Behaviour:
- Reset (async, rst_n=0): state RUN, scoreboard EX/MEM invalid, run counter 0, deadlock 0, counters 0. Outputs during and after reset until inputs change: stall=0, bubble_ex=0, redirect=jump.
- Scoreboard entry = {valid, we, addr, load}. An entry with addr 0 never matches.
- Per-source match: src used, entry valid and we, addr equal.
- Hazard conditions (combinational, current cycle), haz = valid_id AND any of:
  - load-use: EX entry is a load and matches rs or rt.
  - compare-after-ALU: cmp_id and EX entry matches.
  - compare-after-load: cmp_id, MEM entry is a load and matches.
- Priority: ext_stall > haz > run.
- States:
  - HOLD: ext_stall=1. stall=1, bubble_ex=0, scoreboard frozen, run counter frozen.
  - INTERLOCK: haz=1 and no ext_stall. stall=1, bubble_ex=1. At the edge: EX entry becomes invalid, MEM entry takes the old EX entry, run counter increments.
  - RUN: otherwise. stall=0, bubble_ex=0. At the edge: EX entry takes {valid_id, dst_we_id, dst_addr_id, load_id}, MEM entry takes the old EX entry, run counter clears.
- State register records the previous cycle's class, for counters and observability. Outputs are a zero-latency combinational function of inputs and scoreboard.
- redirect=0 whenever stall=1. The delay slot is never flushed.
- Watchdog: when the run counter reaches MAX_STALL, deadlock sets and stays set until reset. Legal code peaks at 2 (branch immediately after a load).
- ext_stall arriving mid-interlock: HOLD takes over. The interlock resumes with identical scoreboard after ext_stall drops.
- Reset mid-operation discards the scoreboard with no pending stall.

Optional Feature:
- PIPELINE_CTRL_PERF_EN defined: stall_cnt increments on each INTERLOCK cycle and hold_cnt on each HOLD cycle. Both wrap modulo 2^CNT_W and clear on reset.
- Not defined: both outputs tied to 0 and no counter flops are built.

Test Plan:
- Load-use: lw $5 in ID (RUN), then add $6,$5,$1 in ID -> one cycle stall=1, bubble_ex=1; next cycle stall=0; stall_cnt=1.
- Branch after ALU: addu $3 then beq $3,$0 with cmp_id=1, jump=1 -> stall=1, redirect=0 for one cycle; then redirect=1.
- Branch after load: lw $4 then beq $4,$4 -> stall for 2 consecutive cycles, redirect only on third; deadlock stays 0 with MAX_STALL=4.
- $0 immunity: lw $0 then add $1,$0,$0 -> stall never asserts.
- ext_stall=1 for 3 cycles during a load-use interlock -> stall=1, bubble_ex=0 those 3 cycles, hold_cnt=3; then the single interlock cycle completes.
- Watchdog and reset: force haz with a frozen scoreboard for 4 cycles -> deadlock=1 on the 4th edge; pulse rst_n low mid-run -> all outputs and counters return to reset values immediately.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard interlock / stall sequencer beside decode; optional perf counters under PIPELINE_CTRL_PERF_EN.
// Latency: stall/bubble_ex/redirect are zero-latency combinational; scoreboard updates on the clock edge.
// Backpressure: ext_stall freezes everything (HOLD); hazards hold ID and inject one EX bubble per cycle.
module pipeline_ctrl #(
    parameter int MAX_STALL = 4,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ext_stall,
    input  logic             valid_id,
    input  logic [4:0]       reg_s_addr,
    input  logic [4:0]       reg_t_addr,
    input  logic             use_s,
    input  logic             use_t,
    input  logic             cmp_id,
    input  logic             jump,
    input  logic             dst_we_id,
    input  logic [4:0]       dst_addr_id,
    input  logic             load_id,
    output logic             stall,
    output logic             bubble_ex,
    output logic             redirect,
    output logic             deadlock,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] hold_cnt
);

    localparam int RC_W = $clog2(MAX_STALL + 1);
    localparam logic [RC_W-1:0] RC_MAX = RC_W'(MAX_STALL);

    typedef struct packed {
        logic       valid;
        logic       we;
        logic [4:0] addr;
        logic       load;
    } sb_entry_t;

    typedef enum logic [1:0] {ST_RUN, ST_INTERLOCK, ST_HOLD} state_t;

    state_t          state_q, state_d;
    sb_entry_t       ex_q, mem_q;
    logic [RC_W-1:0] run_cnt_q, run_cnt_inc;
    logic            deadlock_q;
    logic            s_ex, t_ex, s_mem, t_mem, ex_hit, mem_hit, haz;

    // Register $0 is hardwired zero, so it can never carry a true dependency.
    function automatic logic src_match(input logic used, input logic [4:0] src, input sb_entry_t e);
        return used && e.valid && e.we && (e.addr != 5'd0) && (e.addr == src);
    endfunction

    assign s_ex    = src_match(use_s, reg_s_addr, ex_q);
    assign t_ex    = src_match(use_t, reg_t_addr, ex_q);
    assign s_mem   = src_match(use_s, reg_s_addr, mem_q);
    assign t_mem   = src_match(use_t, reg_t_addr, mem_q);
    assign ex_hit  = s_ex | t_ex;
    assign mem_hit = s_mem | t_mem;
    assign haz     = valid_id & ((ex_q.load & ex_hit) | (cmp_id & ex_hit) | (cmp_id & mem_q.load & mem_hit));

    assign run_cnt_inc = run_cnt_q + RC_W'(1);

    always_comb begin
        state_d   = ST_RUN;
        stall     = 1'b0;
        bubble_ex = 1'b0;
        if (ext_stall) begin
            state_d = ST_HOLD;
            stall   = 1'b1;
        end else if (haz) begin
            state_d   = ST_INTERLOCK;
            stall     = 1'b1;
            bubble_ex = 1'b1;
        end
        redirect = jump & ~stall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            ex_q       <= '0;
            mem_q      <= '0;
            run_cnt_q  <= '0;
            deadlock_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_d)
                ST_HOLD: ;
                ST_INTERLOCK: begin
                    ex_q  <= '0;
                    mem_q <= ex_q;
                    if (run_cnt_q != RC_MAX)
                        run_cnt_q <= run_cnt_inc;
                    if (run_cnt_inc == RC_MAX)
                        deadlock_q <= 1'b1;
                end
                default: begin
                    ex_q  <= {valid_id, dst_we_id, dst_addr_id, load_id};
                    mem_q <= ex_q;
                    // The run counter is already zero after a RUN cycle; only clear when leaving a stall.
                    if (state_q != ST_RUN)
                        run_cnt_q <= '0;
                end
            endcase
        end
    end

    assign deadlock = deadlock_q;

`ifdef PIPELINE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, hold_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            hold_cnt_q  <= '0;
        end else begin
            if (state_d == ST_INTERLOCK)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (state_d == ST_HOLD)
                hold_cnt_q <= hold_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign hold_cnt  = hold_cnt_q;
`else
    assign stall_cnt = '0;
    assign hold_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; a second instance with MAX_STALL=2 exercises the watchdog.
module tb_pipeline_ctrl;

    logic        clk, rst_n;
    logic        ext_stall, valid_id, use_s, use_t, cmp_id, jump, dst_we_id, load_id;
    logic [4:0]  reg_s_addr, reg_t_addr, dst_addr_id;
    logic        stall, bubble_ex, redirect, deadlock;
    logic [31:0] stall_cnt, hold_cnt;
    logic        wd_stall, wd_bubble_ex, wd_redirect, wd_deadlock;
    logic [31:0] wd_stall_cnt, wd_hold_cnt;

    typedef struct packed {
        logic stall;
        logic bubble;
        logic redirect;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    pipeline_ctrl #(.MAX_STALL(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .ext_stall(ext_stall), .valid_id(valid_id),
        .reg_s_addr(reg_s_addr), .reg_t_addr(reg_t_addr), .use_s(use_s), .use_t(use_t),
        .cmp_id(cmp_id), .jump(jump), .dst_we_id(dst_we_id), .dst_addr_id(dst_addr_id),
        .load_id(load_id), .stall(stall), .bubble_ex(bubble_ex), .redirect(redirect),
        .deadlock(deadlock), .stall_cnt(stall_cnt), .hold_cnt(hold_cnt)
    );

    pipeline_ctrl #(.MAX_STALL(2), .CNT_W(32)) wd (
        .clk(clk), .rst_n(rst_n), .ext_stall(ext_stall), .valid_id(valid_id),
        .reg_s_addr(reg_s_addr), .reg_t_addr(reg_t_addr), .use_s(use_s), .use_t(use_t),
        .cmp_id(cmp_id), .jump(jump), .dst_we_id(dst_we_id), .dst_addr_id(dst_addr_id),
        .load_id(load_id), .stall(wd_stall), .bubble_ex(wd_bubble_ex), .redirect(wd_redirect),
        .deadlock(wd_deadlock), .stall_cnt(wd_stall_cnt), .hold_cnt(wd_hold_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] perf(input int unsigned n);
`ifdef PIPELINE_CTRL_PERF_EN
        return 32'(n);
`else
        return (n == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input int unsigned s, input int unsigned h);
        chk({tag, "/stall_cnt"}, stall_cnt, perf(s));
        chk({tag, "/hold_cnt"}, hold_cnt, perf(h));
        chk({tag, "/wd_stall_cnt"}, wd_stall_cnt, perf(s));
    endtask

    // Drive one ID cycle at posedge+1, queue its expected outputs, compare at the following negedge.
    task automatic step(input string tag, input logic ext, input logic vld,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic us, input logic ut, input logic cmp, input logic jmp,
                        input logic we, input logic [4:0] dst, input logic ld,
                        input logic es, input logic eb, input logic er);
        exp_t e;
        ext_stall = ext; valid_id = vld; reg_s_addr = rs; reg_t_addr = rt;
        use_s = us; use_t = ut; cmp_id = cmp; jump = jmp;
        dst_we_id = we; dst_addr_id = dst; load_id = ld;
        exp_q.push_back('{stall: es, bubble: eb, redirect: er});
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s/queue: observed empty expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "/stall"}, stall, e.stall);
            chk({tag, "/bubble_ex"}, bubble_ex, e.bubble);
            chk({tag, "/redirect"}, redirect, e.redirect);
            chk({tag, "/wd_stall"}, wd_stall, e.stall);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nop2();
        step("nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        ext_stall = 0; valid_id = 0; reg_s_addr = 0; reg_t_addr = 0; use_s = 0; use_t = 0;
        cmp_id = 0; jump = 1; dst_we_id = 0; dst_addr_id = 0; load_id = 0;
        #12;
        chk("rst/stall", stall, 0);
        chk("rst/bubble_ex", bubble_ex, 0);
        chk("rst/redirect", redirect, 1);
        chk("rst/deadlock", deadlock, 0);
        chk("rst/wd_deadlock", wd_deadlock, 0);
        chk_cnt("rst", 0, 0);
        rst_n = 1'b1;
        jump = 0;
        @(posedge clk);
        #1;

        // load-use
        step("lw5",    0, 1, 1, 5, 1, 0, 0, 0, 1, 5, 1, 0, 0, 0);
        step("add_lu", 0, 1, 5, 1, 1, 1, 0, 0, 1, 6, 0, 1, 1, 0);
        step("add_go", 0, 1, 5, 1, 1, 1, 0, 0, 1, 6, 0, 0, 0, 0);
        chk_cnt("loaduse", 1, 0);
        nop2();

        // branch after ALU
        step("addu3",   0, 1, 1, 2, 1, 1, 0, 0, 1, 3, 0, 0, 0, 0);
        step("beq_alu", 0, 1, 3, 0, 1, 1, 1, 1, 0, 0, 0, 1, 1, 0);
        step("beq_go",  0, 1, 3, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1);
        nop2();
        chk_cnt("bralu", 2, 0);

        // branch after load: two interlock cycles, watchdog boundary on the MAX_STALL=2 instance
        step("lw4",     0, 1, 1, 4, 1, 0, 0, 0, 1, 4, 1, 0, 0, 0);
        step("beq_ld1", 0, 1, 4, 4, 1, 1, 1, 1, 0, 0, 0, 1, 1, 0);
        chk("brld1/wd_deadlock", wd_deadlock, 0);
        step("beq_ld2", 0, 1, 4, 4, 1, 1, 1, 1, 0, 0, 0, 1, 1, 0);
        chk("brld2/wd_deadlock", wd_deadlock, 1);
        chk("brld2/deadlock", deadlock, 0);
        step("beq_ldgo", 0, 1, 4, 4, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1);
        nop2();
        chk_cnt("brld", 4, 0);
        chk("brld/deadlock", deadlock, 0);

        // $0 never creates a dependency
        step("lw0",    0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        step("add_r0", 0, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        step("beq_r0", 0, 1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1);
        nop2();

        // ext_stall over a pending load-use interlock, jump held to test redirect gating
        step("lw7", 0, 1, 1, 7, 1, 0, 0, 0, 1, 7, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step("hold", 1, 1, 7, 7, 1, 1, 0, 1, 1, 8, 0, 1, 0, 0);
        chk_cnt("hold", 4, 3);
        step("add_lu7", 0, 1, 7, 7, 1, 1, 0, 0, 1, 8, 0, 1, 1, 0);
        step("add_go7", 0, 1, 7, 7, 1, 1, 0, 0, 1, 8, 0, 0, 0, 0);
        nop2();
        chk_cnt("holdend", 5, 3);
        chk("holdend/deadlock", deadlock, 0);
        chk("holdend/wd_deadlock", wd_deadlock, 1);

        // asynchronous reset in the middle of a pending interlock
        step("lw9", 0, 1, 1, 9, 1, 0, 0, 0, 1, 9, 1, 0, 0, 0);
        ext_stall = 0; valid_id = 1; reg_s_addr = 9; reg_t_addr = 9; use_s = 1; use_t = 1;
        cmp_id = 0; jump = 1; dst_we_id = 1; dst_addr_id = 10; load_id = 0;
        #2;
        chk("prerst/stall", stall, 1);
        chk("prerst/redirect", redirect, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst/stall", stall, 0);
        chk("midrst/bubble_ex", bubble_ex, 0);
        chk("midrst/redirect", redirect, 1);
        chk("midrst/wd_deadlock", wd_deadlock, 0);
        chk_cnt("midrst", 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("add_postrst", 0, 1, 9, 9, 1, 1, 0, 1, 1, 10, 0, 0, 0, 1);
        chk_cnt("postrst", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
